// File: rtl/spi_deserializer.sv
// SPI mode-0 receive end: synchronizes DataBit/SPI_clk/CS into clk, shifts MSB first,
// and emits a one-cycle valid (exact FRAME_BITS bits) or frame_err (any other count) at CS rise.
module spi_deserializer #(
  parameter int FRAME_BITS = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  SPI_clk,
  input  logic                  CS,
  input  logic                  DataBit,
  output logic [FRAME_BITS-1:0] Data_Out,
  output logic                  valid,
  output logic                  frame_err,
  output logic                  busy
);

  localparam int CW = $clog2(FRAME_BITS + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(FRAME_BITS);
  localparam logic [CW-1:0] CNT_SAT  = CW'(FRAME_BITS + 1);

  typedef enum logic [1:0] {WAIT_IDLE, IDLE, SHIFT} state_t;

  state_t                state;
  logic                  cs_s1, cs_s2, cs_h;
  logic                  sclk_s1, sclk_s2, sclk_h;
  logic                  dat_s1, dat_s2;
  logic [1:0]            primed;
  logic [FRAME_BITS-1:0] shift;
  logic [CW-1:0]         count;

  logic                  sclk_rise, cs_fall, cs_rise;
  logic [FRAME_BITS-1:0] shift_next;
  logic [CW-1:0]         count_next;

  // primed marks when the synchronizers reflect the pins rather than their reset values,
  // so a reset released while CS is low is never mistaken for an idle bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_s1   <= 1'b1;
      cs_s2   <= 1'b1;
      cs_h    <= 1'b1;
      sclk_s1 <= 1'b0;
      sclk_s2 <= 1'b0;
      sclk_h  <= 1'b0;
      dat_s1  <= 1'b0;
      dat_s2  <= 1'b0;
      primed  <= 2'b00;
    end else begin
      cs_s1   <= CS;
      cs_s2   <= cs_s1;
      cs_h    <= cs_s2;
      sclk_s1 <= SPI_clk;
      sclk_s2 <= sclk_s1;
      sclk_h  <= sclk_s2;
      dat_s1  <= DataBit;
      dat_s2  <= dat_s1;
      primed  <= {primed[0], 1'b1};
    end
  end

  assign sclk_rise = sclk_s2 & ~sclk_h;
  assign cs_fall   = ~cs_s2 & cs_h;
  assign cs_rise   = cs_s2 & ~cs_h;

  // A bit arriving in the same cycle as CS rise is counted before the frame is judged.
  assign shift_next = sclk_rise ? {shift[FRAME_BITS-2:0], dat_s2} : shift;
  assign count_next = (sclk_rise && (count != CNT_SAT)) ? count + CW'(1) : count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= WAIT_IDLE;
      Data_Out  <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
      shift     <= '0;
      count     <= '0;
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        WAIT_IDLE: begin
          busy <= 1'b0;
          if (primed[1] && cs_s2) state <= IDLE;
        end
        IDLE: begin
          if (cs_fall) begin
            state <= SHIFT;
            count <= '0;
            busy  <= 1'b1;
          end
        end
        SHIFT: begin
          shift <= shift_next;
          count <= count_next;
          if (cs_rise) begin
            state <= IDLE;
            busy  <= 1'b0;
            if (count_next == CNT_FULL) begin
              Data_Out <= shift_next;
              valid    <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end
        end
        default: begin
          state <= WAIT_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_deserializer.sv
// Randomized + directed bench: stimulus pushes expected strobes into a queue,
// a negedge monitor pops and compares them against what the deserializer presents.
module tb_spi_deserializer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        SPI_clk;
  logic        CS;
  logic        DataBit;
  logic [31:0] Data_Out;
  logic        valid;
  logic        frame_err;
  logic        busy;

  spi_deserializer #(.FRAME_BITS(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .SPI_clk   (SPI_clk),
    .CS        (CS),
    .DataBit   (DataBit),
    .Data_Out  (Data_Out),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          is_valid;
    logic [31:0] data;
    int          at_cyc;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every strobe must match the next queued expectation, in kind, data and cycle.
  logic [31:0] exp_data = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_data = '0;
    end else if (valid || frame_err) begin
      check("valid_and_err_exclusive", 64'(valid & frame_err), 64'(0));
      if (q.size() == 0) begin
        check("unexpected_strobe", 64'({valid, frame_err}), 64'(0));
      end else begin
        exp_t e;
        e = q.pop_front();
        check("strobe_kind", 64'(valid), 64'(e.is_valid));
        check("strobe_cycle", 64'(cyc), 64'(e.at_cyc));
        if (e.is_valid) exp_data = e.data;
        check("data_out", 64'(Data_Out), 64'(exp_data));
      end
    end
  end

  task automatic wait_clk(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  task automatic shift_bit(input logic b, input int half);
    DataBit = b;
    wait_clk(half);
    SPI_clk = 1'b1;
    wait_clk(half);
    SPI_clk = 1'b0;
  endtask

  // Reference: a frame of exactly 32 bits yields its bits as the word; anything else is an error.
  task automatic expect_end(input logic [63:0] bits, input int n);
    exp_t e;
    e.is_valid = (n == 32);
    e.data     = bits[31:0];
    e.at_cyc   = cyc + 3;
    q.push_back(e);
  endtask

  task automatic raise_cs_and_check(input logic [63:0] bits, input int n);
    CS = 1'b1;
    expect_end(bits, n);
    wait_clk(2);
    check("busy_until_rise", 64'(busy), 64'(1));
    wait_clk(1);
    check("busy_drop", 64'(busy), 64'(0));
  endtask

  task automatic send_frame(input logic [63:0] bits, input int n, input int half,
                            input int gap, input bit sim_end);
    CS = 1'b0;
    wait_clk(2);
    check("busy_before_fall", 64'(busy), 64'(0));
    wait_clk(1);
    check("busy_after_fall", 64'(busy), 64'(1));
    wait_clk(half);
    for (int i = 0; i < n; i++) begin
      if (sim_end && i == n - 1) begin
        DataBit = bits[n-1-i];
        wait_clk(half);
        SPI_clk = 1'b1;
        raise_cs_and_check(bits, n);
        wait_clk(half - 3);
        SPI_clk = 1'b0;
      end else begin
        shift_bit(bits[n-1-i], half);
      end
    end
    if (!sim_end) begin
      wait_clk(half);
      raise_cs_and_check(bits, n);
    end
    wait_clk(gap - 3);
  endtask

  initial begin
    rst_n = 1'b0; CS = 1'b1; SPI_clk = 1'b0; DataBit = 1'b0;
    wait_clk(3);
    check("rst_data_out", 64'(Data_Out), 64'(0));
    check("rst_valid", 64'(valid), 64'(0));
    check("rst_frame_err", 64'(frame_err), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    rst_n = 1'b1;
    wait_clk(5);

    // Single frame, SPI_clk period 20 clk
    send_frame(64'h009E6C8D, 32, 10, 8, 1'b0);
    // Back-to-back with CS high 4 clk
    send_frame(64'h009E6C8D, 32, 4, 4, 1'b0);
    send_frame(64'h0080F0FF, 32, 4, 8, 1'b0);
    // Good, short, long
    send_frame(64'h12345678, 32, 3, 6, 1'b0);
    send_frame(64'h7FFFFFFF, 31, 3, 6, 1'b0);
    send_frame(64'h1ABCDEF01, 33, 3, 6, 1'b0);

    // CS low 5 clk, no SPI_clk
    CS = 1'b0;
    wait_clk(5);
    CS = 1'b1;
    expect_end(64'h0, 0);
    wait_clk(8);
    for (int i = 0; i < 8; i++) begin
      SPI_clk = 1'b1;
      wait_clk(4);
      SPI_clk = 1'b0;
      wait_clk(4);
      check("busy_idle_toggle", 64'(busy), 64'(0));
    end

    // Reset mid-frame, finish it, then a full frame
    CS = 1'b0;
    wait_clk(4);
    for (int i = 0; i < 10; i++) shift_bit(1'($urandom_range(0, 1)), 4);
    rst_n = 1'b0;
    wait_clk(2);
    rst_n = 1'b1;
    for (int i = 0; i < 22; i++) shift_bit(1'($urandom_range(0, 1)), 4);
    wait_clk(4);
    CS = 1'b1;
    wait_clk(10);
    check("busy_after_reset_frame", 64'(busy), 64'(0));
    send_frame(64'hA5A5A5A5, 32, 4, 8, 1'b0);

    // 32nd SPI_clk rise coincides with CS rise
    send_frame(64'hFFFFFFFF, 32, 4, 8, 1'b1);

    // Randomized frames: mostly exact length, some wrong lengths
    for (int f = 0; f < 12; f++) begin
      logic [63:0] bits;
      int n;
      bits = {$urandom, $urandom};
      n = ($urandom_range(0, 9) < 7) ? 32 : int'($urandom_range(0, 36));
      send_frame(bits, n, int'($urandom_range(3, 6)), int'($urandom_range(4, 9)),
                 1'($urandom_range(0, 1)) && (n > 0));
    end

    wait_clk(20);
    check("queue_drained", 64'(q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
